// File: rtl/slave_fifo_mux_writer.sv
// rtl/slave_fifo_mux_writer.sv - round-robin N-channel message writer into the FX2 slave FIFO
//
// Each granted message is sent as one packet: header {2'b10, ch, len}, then
// the data words, then PKTEND.
// Ports:
//   CLK, RST      ifclk and asynchronous active-high reset
//   ENABLE        allows new messages to start (an active packet always completes)
//   CH_GOT_MSG    per-channel "message ready"; CH_LEN / CH_Q are its length and FIFO head word
//   CH_RDRQ       per-channel FIFO advance (combinational)
//   CH_DONE       per-channel packet-committed pulse
//   FLAG_FULL     FX2 full flag, active low
//   FD_OUT/FD_OE  slave FIFO data bus and its tristate enable
//   SLWR/PKTEND   active-low write and packet-end strobes
//   SLOE/SLRD/FIFOADR  constant slave FIFO controls
module slave_fifo_mux_writer #(
  parameter int         N_CH    = 4,
  parameter logic [1:0] EP_ADDR = 2'b10,
  parameter int         LEN_W   = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic [N_CH-1:0]       CH_GOT_MSG,
  input  logic [N_CH*LEN_W-1:0] CH_LEN,
  input  logic [N_CH*16-1:0]    CH_Q,
  output logic [N_CH-1:0]       CH_RDRQ,
  output logic [N_CH-1:0]       CH_DONE,
  input  logic                  FLAG_FULL,
  output logic [15:0]           FD_OUT,
  output logic                  FD_OE,
  output logic                  SLWR,
  output logic                  PKTEND,
  output logic                  SLOE,
  output logic                  SLRD,
  output logic [1:0]            FIFOADR
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, PKT, GAP} state_t;

  state_t            state, state_next;
  logic [3:0]        sel;
  logic [3:0]        last_grant;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  remaining;

  logic [3:0]        grant;
  logic [3:0]        grant_hi;
  logic [3:0]        grant_lo;
  logic              found_hi;
  logic [LEN_W-1:0]  len_grant;
  logic [15:0]       q_sel;

  assign SLOE    = 1'b1;
  assign SLRD    = 1'b1;
  assign FIFOADR = EP_ADDR;

  // Round robin: first requester strictly above last_grant, otherwise the
  // lowest requester overall (the wrap). Descending loops leave the lowest match.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (CH_GOT_MSG[j]) begin
        grant_lo = 4'(j);
        if (4'(j) > last_grant) begin
          grant_hi = 4'(j);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  always_comb begin
    len_grant = '0;
    q_sel     = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (grant == 4'(j)) len_grant = CH_LEN[j*LEN_W +: LEN_W];
      if (sel == 4'(j))   q_sel     = CH_Q[j*16 +: 16];
    end
  end

  // The FIFO advance must be combinational so the show-ahead head word moves
  // on the same edge that captures it into FD_OUT.
  always_comb begin
    CH_RDRQ = '0;
    if (state == DATA && FLAG_FULL) begin
      for (int j = 0; j < N_CH; j++) begin
        if (sel == 4'(j)) CH_RDRQ[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ENABLE && (|CH_GOT_MSG)) state_next = HDR;
      HDR:  if (FLAG_FULL) state_next = (len != '0) ? DATA : PKT;
      DATA: if (FLAG_FULL && remaining == LEN_W'(1)) state_next = PKT;
      PKT:  if (FLAG_FULL) state_next = GAP;
      GAP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered datapath. Strobes default inactive each cycle, so a full FIFO
  // simply produces no strobe while everything else holds.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FD_OUT     <= '0;
      FD_OE      <= 1'b0;
      SLWR       <= 1'b1;
      PKTEND     <= 1'b1;
      CH_DONE    <= '0;
      sel        <= '0;
      len        <= '0;
      remaining  <= '0;
      last_grant <= 4'(N_CH - 1);
    end else begin
      SLWR    <= 1'b1;
      PKTEND  <= 1'b1;
      CH_DONE <= '0;
      case (state)
        IDLE: begin
          if (ENABLE && (|CH_GOT_MSG)) begin
            sel        <= grant;
            len        <= len_grant;
            last_grant <= grant;
            FD_OE      <= 1'b1;
          end
        end
        HDR: begin
          if (FLAG_FULL) begin
            FD_OUT    <= {2'b10, sel, len};
            SLWR      <= 1'b0;
            remaining <= len;
          end
        end
        DATA: begin
          if (FLAG_FULL) begin
            FD_OUT    <= q_sel;
            SLWR      <= 1'b0;
            remaining <= remaining - LEN_W'(1);
          end
        end
        PKT: begin
          if (FLAG_FULL) begin
            PKTEND <= 1'b0;
            for (int j = 0; j < N_CH; j++) begin
              if (sel == 4'(j)) CH_DONE[j] <= 1'b1;
            end
          end
        end
        GAP: FD_OE <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/slave_fifo_mux_writer.md
Name: slave_fifo_mux_writer

Overview:
- N-channel successor to the single-channel SPI-to-FX2 write path.
- Takes complete messages from N_CH per-channel show-ahead word FIFOs, filled by input_process_spi instances, and arbitrates between them round-robin.
- Writes each message to the Cypress slave FIFO as one packet: one header word (channel and length), then the data words, then PKTEND.
- Sits between the per-channel SPI capture blocks and the FD/SLWR/PKTEND pins, all on ifclk.

Parameters:
- N_CH, 4, number of input channels (1..16).
- EP_ADDR, 2'b10, constant value driven on FIFOADR (the IN endpoint).
- LEN_W, 10, width of each channel length field; maximum message length is 2^LEN_W-1 words (fixed at 10 for the header format).

Ports:
- CLK  in  1  ifclk; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  when low, no new message is started; a message already in progress completes.
- CH_GOT_MSG  in  N_CH  per channel: a complete message is waiting; held high until CH_DONE.
- CH_LEN  in  N_CH*LEN_W  per-channel message length in words; stable while CH_GOT_MSG is high.
- CH_Q  in  N_CH*16  per-channel show-ahead FIFO head word.
- CH_RDRQ  out  N_CH  per-channel FIFO advance; combinational, one cycle per consumed word.
- CH_DONE  out  N_CH  one-cycle pulse when that channel's message packet is committed.
- FLAG_FULL  in  1  FX2 FLAGB, active-low (0 = FIFO full).
- FD_OUT  out  16  slave FIFO data.
- FD_OE  out  1  output enable for the FD tristate at top level.
- SLWR  out  1  active-low write strobe.
- PKTEND  out  1  active-low packet end.
- SLOE  out  1  constant 1.
- SLRD  out  1  constant 1.
- FIFOADR  out  2  constant EP_ADDR.

Behaviour:
- Reset values: SLWR=1, PKTEND=1, FD_OE=0, FD_OUT=0, CH_RDRQ=0, CH_DONE=0, state=IDLE, last_grant=N_CH-1 (so channel 0 wins first).
- All outputs are registered except CH_RDRQ. Asserting RST mid-packet aborts immediately; the partial packet is not terminated with PKTEND and no CH_DONE is issued.
- State IDLE:
  - If ENABLE=1 and CH_GOT_MSG is nonzero, grant the first requesting channel searching from (last_grant+1) mod N_CH upward with wrap.
  - On grant: latch sel, latch len=CH_LEN[sel], set last_grant=sel, go to HDR.
- State HDR: FD_OE=1. On a cycle with FLAG_FULL=1, write the header:
  - FD_OUT={2'b10, sel[3:0], len[9:0]}, SLWR=0 for exactly one cycle.
  - Next state: DATA if len>0, else PKT.
- State DATA: on each cycle with FLAG_FULL=1:
  - CH_RDRQ[sel]=1 in that same cycle.
  - FD_OUT=CH_Q[sel] captured, SLWR=0 during the next cycle.
  - Decrement remaining; after the last word go to PKT.
- FLAG_FULL=0 in HDR/DATA/PKT: no write, no RDRQ, SLWR=1, state and counters hold. Writes resume on the first cycle FLAG_FULL returns to 1.
- Back-to-back writes are allowed: SLWR may stay low for consecutive cycles (one word per cycle).
- State PKT: on a cycle with FLAG_FULL=1:
  - PKTEND=0 for one cycle.
  - CH_DONE[sel]=1 for one cycle, coincident with PKTEND.
  - Go to GAP.
- State GAP: one cycle; FD_OE=0, SLWR=1, PKTEND=1. Go to IDLE; the channel's source must drop CH_GOT_MSG within this cycle.
- Minimum overhead per packet: IDLE(1) + HDR(1) + PKT(1) + GAP(1) cycles beyond the data words.
- Simultaneous requests: strict round-robin; a channel cannot win twice in a row while another channel is requesting.
- ENABLE falling mid-packet: no effect until the packet completes; the block then stays in IDLE.
- CH_GOT_MSG on an unselected channel changing mid-packet: ignored until IDLE.
- len=0: packet is the header only, then PKTEND.

Test Plan:
- Reset, ch1 GOT_MSG, LEN=3, words 0x1111/0x2222/0x3333, FLAG_FULL=1 -> SLWR low for 4 consecutive cycles carrying FD 0x8403, 0x1111, 0x2222, 0x3333; CH_RDRQ[1] pulsed 3 times; then PKTEND and CH_DONE[1] low/high 1 cycle.
- All 4 channels request with LEN=1 -> headers appear in channel order 0,1,2,3; channel 0 re-requesting after its packet is served after channel 3.
- FLAG_FULL=0 for 5 cycles after the 2nd data word of a 4-word message -> no SLWR/RDRQ during the stall; words 3-4 follow the release; total of exactly 4 RDRQ pulses.
- ch2 with LEN=0 -> single write 0x8800, then PKTEND; no CH_RDRQ.
- ENABLE dropped during DATA of ch0 (LEN=8) -> all 8 words and PKTEND complete; a pending ch3 is not started until ENABLE=1.
- RST asserted during DATA -> next cycle SLWR=1, FD_OE=0, PKTEND=1, state IDLE; after release, ch0 has priority.
